// File: rtl/rv_bus_pkg.sv
// Shared types and constants for the fetch/LSU bus arbiter.
// No clocked logic; latency and backpressure do not apply.
package rv_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT_IF  = 2'd1,
        ST_GRANT_LSU = 2'd2,
        ST_RESP      = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_LSU   = 1'b1
    } arb_grant_t;

    localparam logic [3:0] BUS_SEL_WORD = 4'hF;

    function automatic logic [31:0] fetch_byte_addr(input logic [29:0] word_addr);
        return {word_addr, 2'b00};
    endfunction

endpackage

// File: rtl/rv_bus_watchdog.sv
// Grant-state watchdog: o_expired is high in the cycle the count equals TIMEOUT_CYCLES-1.
// One-cycle registered strobe; i_clear arms at grant entry, i_enable counts, neither resets.
module rv_bus_watchdog
#(
    parameter int TIMEOUT_CYCLES = 255
)
(
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_expired;

    assign w_count_inc = r_count + CNT_W'(1);
    assign o_expired   = r_expired;

    // The flag is computed from the next count so it lines up with the count itself.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end else if (i_clear) begin
            r_count   <= '0;
            r_expired <= (CNT_LAST == '0);
        end else if (i_enable) begin
            r_count   <= w_count_inc;
            r_expired <= (w_count_inc == CNT_LAST);
        end else begin
            r_count   <= '0;
            r_expired <= 1'b0;
        end
    end

endmodule

// File: rtl/rv_bus_arbiter.sv
// Fetch/LSU bus arbiter: one access at a time, ack two cycles after request on a zero-wait bus.
// Requesters hold req until ack; RV_ARB_ROUND_ROBIN_EN selects round-robin, else LSU priority.
module rv_bus_arbiter
    import rv_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 255,
    parameter int RESET_LAST_GRANT = 0
)
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_if_req,
    input  logic [31:2] i_if_addr,
    output logic        o_if_ack,
    output logic        o_if_err,
    output logic [31:0] o_if_data,
    input  logic        i_lsu_req,
    input  logic        i_lsu_write,
    input  logic [31:0] i_lsu_addr,
    input  logic [3:0]  i_lsu_sel,
    input  logic [31:0] i_lsu_wdata,
    output logic        o_lsu_ack,
    output logic        o_lsu_err,
    output logic [31:0] o_lsu_rdata,
    output logic        o_bus_stb,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    arb_state_t  r_state;
    logic        r_if_ack;
    logic        r_if_err;
    logic [31:0] r_if_data;
    logic        r_lsu_ack;
    logic        r_lsu_err;
    logic [31:0] r_lsu_rdata;
    logic        r_bus_stb;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_sel;
    logic [31:0] r_bus_wdata;

    logic        w_any_req;
    logic        w_grant_lsu;
    logic        w_in_grant;
    logic        w_wd_clear;
    logic        w_wd_enable;
    logic        w_expired;

    assign w_any_req  = i_if_req | i_lsu_req;
    assign w_in_grant = (r_state == ST_GRANT_IF) || (r_state == ST_GRANT_LSU);

`ifdef RV_ARB_ROUND_ROBIN_EN
    localparam arb_grant_t LAST_GRANT_INIT = (RESET_LAST_GRANT != 0) ? GRANT_LSU : GRANT_FETCH;
    arb_grant_t r_last_grant;

    assign w_grant_lsu = i_lsu_req && (!i_if_req || (r_last_grant == GRANT_FETCH));
`else
    assign w_grant_lsu = i_lsu_req;
`endif

    // Counter stops on the exit cycle so it reads zero throughout RESP.
    assign w_wd_clear  = (r_state == ST_IDLE) && w_any_req;
    assign w_wd_enable = w_in_grant && !i_bus_ack && !w_expired;

    rv_bus_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_clear    (w_wd_clear),
        .i_enable   (w_wd_enable),
        .o_expired  (w_expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= ST_IDLE;
            r_if_ack    <= 1'b0;
            r_if_err    <= 1'b0;
            r_if_data   <= '0;
            r_lsu_ack   <= 1'b0;
            r_lsu_err   <= 1'b0;
            r_lsu_rdata <= '0;
            r_bus_stb   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
`ifdef RV_ARB_ROUND_ROBIN_EN
            r_last_grant <= LAST_GRANT_INIT;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_lsu) begin
                        r_state     <= ST_GRANT_LSU;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= i_lsu_write;
                        r_bus_addr  <= i_lsu_addr;
                        r_bus_sel   <= i_lsu_sel;
                        r_bus_wdata <= i_lsu_wdata;
`ifdef RV_ARB_ROUND_ROBIN_EN
                        r_last_grant <= GRANT_LSU;
`endif
                    end else if (i_if_req) begin
                        r_state     <= ST_GRANT_IF;
                        r_bus_stb   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= fetch_byte_addr(i_if_addr);
                        r_bus_sel   <= BUS_SEL_WORD;
                        r_bus_wdata <= '0;
`ifdef RV_ARB_ROUND_ROBIN_EN
                        r_last_grant <= GRANT_FETCH;
`endif
                    end
                end
                // Ack is tested before expiry so a same-cycle ack is never reported as an error.
                ST_GRANT_IF: begin
                    if (i_bus_ack || w_expired) begin
                        r_state   <= ST_RESP;
                        r_bus_stb <= 1'b0;
                        r_bus_we  <= 1'b0;
                        r_if_ack  <= 1'b1;
                        r_if_err  <= !i_bus_ack;
                        r_if_data <= i_bus_ack ? i_bus_rdata : 32'h0;
                    end
                end
                ST_GRANT_LSU: begin
                    if (i_bus_ack || w_expired) begin
                        r_state     <= ST_RESP;
                        r_bus_stb   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_lsu_ack   <= 1'b1;
                        r_lsu_err   <= !i_bus_ack;
                        r_lsu_rdata <= i_bus_ack ? i_bus_rdata : 32'h0;
                    end
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_if_ack  <= 1'b0;
                    r_if_err  <= 1'b0;
                    r_lsu_ack <= 1'b0;
                    r_lsu_err <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_if_ack    = r_if_ack;
    assign o_if_err    = r_if_err;
    assign o_if_data   = r_if_data;
    assign o_lsu_ack   = r_lsu_ack;
    assign o_lsu_err   = r_lsu_err;
    assign o_lsu_rdata = r_lsu_rdata;
    assign o_bus_stb   = r_bus_stb;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_sel   = r_bus_sel;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: doc/rv_bus_arbiter.md
# rv_bus_arbiter

Single-master bus arbiter sharing one memory bus between the instruction-fetch port and the load/store (LSU) port of the RISC-V core. It runs one bus transaction at a time, chooses between the two requesters, and returns read data with a one-cycle acknowledge. A bus watchdog turns a bus that never acknowledges into an error response. The block sits between the core pipeline and the memory/peripheral interconnect; the fetch-stall and LSU-stall logic in the core is driven from its acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 255: number of cycles spent in a grant state without `i_bus_ack` before the access is aborted with an error. Range 1..65535.
- `RESET_LAST_GRANT`, default 0: initial value of the last-grant record. 0 = fetch, 1 = LSU.

Ports:
- `i_clk`  in  1: clock.
- `i_reset_n`  in  1: reset, asynchronous, active-low.
- `i_if_req`  in  1: fetch request.
- `i_if_addr`  in  [31:2]: fetch word address.
- `o_if_ack`  out  1: one-cycle fetch completion.
- `o_if_err`  out  1: fetch timed out. Valid with `o_if_ack`.
- `o_if_data`  out  32: fetched word. Valid with `o_if_ack`.
- `i_lsu_req`  in  1: LSU request.
- `i_lsu_write`  in  1: 1 = store, 0 = load.
- `i_lsu_addr`  in  32: byte address.
- `i_lsu_sel`  in  4: byte lanes.
- `i_lsu_wdata`  in  32: store data.
- `o_lsu_ack`  out  1: one-cycle LSU completion.
- `o_lsu_err`  out  1: LSU access timed out.
- `o_lsu_rdata`  out  32: load data.
- `o_bus_stb`  out  1: bus strobe (also acts as cycle valid).
- `o_bus_we`  out  1: bus write enable.
- `o_bus_addr`  out  32: bus byte address.
- `o_bus_sel`  out  4: bus byte lanes.
- `o_bus_wdata`  out  32: bus write data.
- `i_bus_ack`  in  1: bus completion.
- `i_bus_rdata`  in  32: bus read data.

## Operation
The FSM has four states: IDLE, GRANT_IF, GRANT_LSU, RESP.

- **IDLE**
  - No request: stay in IDLE.
  - Exactly one request: go to that port's grant state.
  - Both requests: arbitration rule per Configuration.
  - On the transition, register the bus outputs:
    - `o_bus_stb` = 1.
    - Fetch: `o_bus_addr` = {`i_if_addr`, 2'b00}, `o_bus_sel` = 4'hF, `o_bus_we` = 0.
    - LSU: the LSU payload.
- **GRANT_x**
  - The watchdog counter increments every cycle.
  - On `i_bus_ack`:
    - Capture `i_bus_rdata` into `o_x_data`/`o_x_rdata`. Stores also capture it; the value is don't-care.
    - Drop `o_bus_stb`/`o_bus_we`, go to RESP, and set `o_x_ack`.
  - On counter == `TIMEOUT_CYCLES - 1` without ack:
    - Drop the strobe, go to RESP, and set `o_x_ack` and `o_x_err`.
    - Captured data = 32'h0.
  - If `i_bus_ack` and timeout occur in the same cycle, the ack wins and no error is flagged.
- **RESP**
  - `o_x_ack` is high for exactly this cycle. Next state is IDLE, and the counter clears.
  - Requests are ignored in RESP.
  - The requester retires its request on the RESP edge. It may reassert `req` with a new payload from the following cycle.
- **Requester rules**
  - Hold `req` and the payload stable from assertion until `o_x_ack`.
  - The arbiter samples the payload only on the IDLE→GRANT edge.
  - Dropping `req` before ack is illegal. The arbiter completes the granted access regardless.
- Acknowledged `i_bus_ack` outside the grant states is ignored.
- The last-grant record updates on each IDLE→GRANT transition.

## Timing
- Reset values:
  - All outputs 0, including data outputs.
  - State IDLE, counter 0, last-grant = `RESET_LAST_GRANT`.
- Reset asserted mid-transaction: `o_bus_stb` drops asynchronously and no ack is issued. The requester reissues after reset.
- Zero-wait bus:
  - Request seen in IDLE at cycle 0.
  - `o_bus_stb` high in cycle 1; the bus acks in cycle 1.
  - `o_x_ack` in cycle 2; IDLE in cycle 3.
  - Peak throughput: one access per 3 cycles.
- N bus wait states: ack at cycle 2+N.
- Timeout: `o_x_ack`/`o_x_err` at cycle `TIMEOUT_CYCLES` + 1.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `RV_ARB_ROUND_ROBIN_EN` defined: on simultaneous requests in IDLE, grant the port that was not granted last.
- Undefined: fixed priority, LSU always beats fetch. Fetch starvation under continuous LSU requests is accepted.
- A single requester is granted immediately in both modes.

## Structure
- Package `rv_bus_pkg` holds:
  - `arb_state_t` enum (IDLE, GRANT_IF, GRANT_LSU, RESP).
  - `arb_grant_t` enum (GRANT_FETCH, GRANT_LSU).
  - Constant `BUS_SEL_WORD` = 4'hF.
- Sub-module `rv_bus_watchdog` contains the counter. Ports: clear, enable, and a registered `o_expired` strobe. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

## Test plan
1. Fetch only, `i_if_addr` = 30'h100, bus acks in the first strobe cycle with 32'h00000013.
   - Required: `o_bus_addr` = 32'h400, sel F, we 0.
   - Required: `o_if_ack` 2 cycles after the request, `o_if_data` = 32'h00000013.
2. LSU store, addr 32'h2000, sel 4'b0011, wdata 32'hBEEF, bus ack after 3 waits.
   - Required: `o_bus_we` = 1 and the payload held for 4 cycles.
   - Required: `o_lsu_ack` at cycle 5, `o_lsu_err` = 0.
3. Both ports request continuously, 6 transactions.
   - Without the macro: all 6 grants go to LSU.
   - With the macro: grants alternate, LSU first (`RESET_LAST_GRANT` = 0).
4. `TIMEOUT_CYCLES` = 4, bus never acks.
   - Required: strobe high 4 cycles, then `o_lsu_ack` = `o_lsu_err` = 1, `o_lsu_rdata` = 0, state back to IDLE.
5. `i_reset_n` dropped while in GRANT_IF.
   - Required: `o_bus_stb` = 0 immediately, no `o_if_ack`.
   - Required: after release, the first request completes normally.
6. Ack and timeout in the same cycle (ack at the 4th strobe cycle, `TIMEOUT_CYCLES` = 4).
   - Required: ack with err = 0 and the bus data captured.
